// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
// Groups the instruction-memory handshake, the redirect input and the
// decoder-side handshake of the fetch unit into one bundle.
//
// Signals
//   imem_req_valid / imem_req_ready / imem_req_addr : fetch request channel
//   imem_rsp_valid / imem_rsp_data                  : in-order response, no
//                                                     backpressure
//   redirect_valid / redirect_pc                    : control-flow redirect
//   if_valid / if_instr / if_pc / if_ready          : delivery to decoder
//
// Modports
//   master : the fetch unit side
//   slave  : the environment side (memory, back end, decoder)
// ----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Issues word-aligned fetch requests from a
// program counter, tracks up to two in-flight requests, buffers up to two
// returned instructions and hands them to the decoder in order. A redirect
// flushes the buffer, restarts fetch at the new target and discards the
// responses of every request that was still in flight.
//
// Parameters
//   RESET_PC : first fetch address after reset
//
// Ports
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : fetch_unit_if.master (memory, redirect and decoder channels)
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  // fetch pointer
  logic [31:0] pc;

  // outstanding-address queue: addresses of live (non-discarded) requests
  logic [31:0] q_addr [2];
  logic        q_rd;
  logic [1:0]  q_cnt;
  logic        q_wr;

  // responses still owed by memory for requests killed by a redirect
  logic [1:0]  disc_cnt;

  // instruction buffer
  logic [31:0] b_data [2];
  logic [31:0] b_pc   [2];
  logic        b_rd;
  logic [1:0]  b_cnt;
  logic        b_wr;

  logic [2:0]  pending;
  logic [1:0]  in_flight;
  logic        redirect;
  logic        req_valid;
  logic        req_fire;
  logic        rsp_take;
  logic        rsp_drop;
  logic        if_valid;
  logic        if_pop;

  assign redirect  = bus.redirect_valid;

  // Every issued request reserves a buffer slot until it is delivered, and a
  // killed request keeps its reservation until its response has been seen.
  // Hence a response can always be buffered without backpressure.
  assign pending   = {1'b0, q_cnt} + {1'b0, disc_cnt} + {1'b0, b_cnt};
  assign in_flight = q_cnt + disc_cnt;

  assign req_valid = !rst && !redirect && (pending < 3'd2);
  assign req_fire  = req_valid && bus.imem_req_ready;

  // A response either belongs to a killed request (drop) or to the oldest
  // live request (buffer). In the redirect cycle itself it is always dropped.
  assign rsp_take  = !rst && !redirect && bus.imem_rsp_valid && (disc_cnt == 2'd0);
  assign rsp_drop  = !rst && !redirect && bus.imem_rsp_valid && (disc_cnt != 2'd0);

  assign if_valid  = !rst && (b_cnt != 2'd0);
  assign if_pop    = if_valid && bus.if_ready && !redirect;

  // write slots sit "count" entries past the read pointer (2-entry rings)
  assign q_wr      = q_rd ^ q_cnt[0];
  assign b_wr      = b_rd ^ b_cnt[0];

  // ---- control state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      q_rd     <= 1'b0;
      q_cnt    <= 2'd0;
      disc_cnt <= 2'd0;
      b_rd     <= 1'b0;
      b_cnt    <= 2'd0;
    end else if (redirect) begin
      // Everything in flight becomes a discard; a response arriving now is
      // the oldest of those and is accounted for immediately.
      pc       <= {bus.redirect_pc[31:2], 2'b00};
      q_rd     <= 1'b0;
      q_cnt    <= 2'd0;
      disc_cnt <= in_flight - 2'(bus.imem_rsp_valid && (in_flight != 2'd0));
      b_rd     <= 1'b0;
      b_cnt    <= 2'd0;
    end else begin
      if (req_fire) begin
        pc <= pc + 32'd4;
      end
      if (rsp_take) begin
        q_rd <= ~q_rd;
      end
      q_cnt    <= q_cnt + 2'(req_fire) - 2'(rsp_take);
      disc_cnt <= disc_cnt - 2'(rsp_drop);
      if (if_pop) begin
        b_rd <= ~b_rd;
      end
      b_cnt    <= b_cnt + 2'(rsp_take) - 2'(if_pop);
    end
  end

  // ---- data storage (qualified by the counters above, so not reset) ----
  always_ff @(posedge clk) begin
    if (req_fire) begin
      q_addr[q_wr] <= pc;
    end
    if (rsp_take) begin
      b_data[b_wr] <= bus.imem_rsp_data;
      b_pc[b_wr]   <= q_addr[q_rd];
    end
  end

  // ---- outputs ----
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = rst ? RESET_PC : pc;
  assign bus.if_valid       = if_valid;
  assign bus.if_instr       = if_valid ? b_data[b_rd] : 32'd0;
  assign bus.if_pc          = if_valid ? b_pc[b_rd]   : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_1000;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // response source: either a 1-cycle memory model or direct table drive
  logic        use_model;
  logic        mdl_v;
  logic [31:0] mdl_d;
  logic        tbl_v;
  logic [31:0] tbl_d;

  always @(posedge clk) begin
    mdl_v <= bus.imem_req_valid && bus.imem_req_ready && !rst;
    mdl_d <= 32'hC000_0000 | bus.imem_req_addr;
  end

  assign bus.imem_rsp_valid = use_model ? mdl_v : tbl_v;
  assign bus.imem_rsp_data  = use_model ? mdl_d : tbl_d;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        rdr;
    logic [31:0] rpc;
    logic        ifr;
    logic        rv;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] ipc;
    logic [31:0] iins;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // one clock cycle: drive inputs mid-cycle, then let outputs settle
  task automatic cyc(input logic r, input logic rdy, input logic ifr,
                     input logic rdr, input logic [31:0] rpc,
                     input logic rv, input logic [31:0] rd);
    @(negedge clk);
    rst                = r;
    bus.imem_req_ready = rdy;
    bus.if_ready       = ifr;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
    tbl_v              = rv;
    tbl_d              = rd;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    int          delivered;
    logic [31:0] exp_pc;

    n_run              = 0;
    n_fail             = 0;
    rst                = 1'b1;
    use_model          = 1'b0;
    tbl_v              = 1'b0;
    tbl_d              = 32'd0;
    bus.imem_req_ready = 1'b0;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    //            rst rdy rspv rspd           rdr rpc ifr | rv addr          ifv ipc           iins
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,1'b0, 1'b0,32'h0000_1000,1'b0,32'h0,        32'h0};
    vecs[1]  = '{1'b1,1'b1,1'b1,32'hDEAD_BEEF,1'b0,32'h0,1'b1, 1'b0,32'h0000_1000,1'b0,32'h0,        32'h0};
    vecs[2]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,1'b1, 1'b1,32'h0000_1000,1'b0,32'h0,        32'h0};
    vecs[3]  = '{1'b0,1'b1,1'b1,32'hC000_1000,1'b0,32'h0,1'b1, 1'b1,32'h0000_1004,1'b0,32'h0,        32'h0};
    vecs[4]  = '{1'b0,1'b1,1'b1,32'hC000_1004,1'b0,32'h0,1'b1, 1'b0,32'h0000_1008,1'b1,32'h0000_1000,32'hC000_1000};
    vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,1'b1, 1'b1,32'h0000_1008,1'b1,32'h0000_1004,32'hC000_1004};
    vecs[6]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,1'b1, 1'b1,32'h0000_1008,1'b0,32'h0,        32'h0};
    vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,1'b1, 1'b1,32'h0000_1008,1'b0,32'h0,        32'h0};
    vecs[8]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,1'b1, 1'b1,32'h0000_1008,1'b0,32'h0,        32'h0};
    vecs[9]  = '{1'b0,1'b1,1'b1,32'hC000_1008,1'b0,32'h0,1'b0, 1'b1,32'h0000_100C,1'b0,32'h0,        32'h0};
    vecs[10] = '{1'b0,1'b1,1'b1,32'hC000_100C,1'b0,32'h0,1'b0, 1'b0,32'h0000_1010,1'b1,32'h0000_1008,32'hC000_1008};
    vecs[11] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,1'b0, 1'b0,32'h0000_1010,1'b1,32'h0000_1008,32'hC000_1008};
    vecs[12] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,1'b1, 1'b0,32'h0000_1010,1'b1,32'h0000_1008,32'hC000_1008};
    vecs[13] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,1'b1, 1'b1,32'h0000_1010,1'b1,32'h0000_100C,32'hC000_100C};
    vecs[14] = '{1'b0,1'b0,1'b1,32'hC000_1010,1'b0,32'h0,1'b1, 1'b1,32'h0000_1014,1'b0,32'h0,        32'h0};
    vecs[15] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,1'b0, 1'b1,32'h0000_1014,1'b1,32'h0000_1010,32'hC000_1010};

    // ---- table-driven: reset, startup, stall stability, buffer fill/drain ----
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].rst, vecs[i].rdy, vecs[i].ifr, vecs[i].rdr, vecs[i].rpc,
          vecs[i].rspv, vecs[i].rspd);
      chk($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].rv));
      chk($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vecs[i].addr);
      chk($sformatf("vec%0d_if_valid", i), 32'(bus.if_valid), 32'(vecs[i].ifv));
      if (vecs[i].ifv || vecs[i].rst) begin
        chk($sformatf("vec%0d_if_pc", i), bus.if_pc, vecs[i].ipc);
        chk($sformatf("vec%0d_if_instr", i), bus.if_instr, vecs[i].iins);
      end
    end

    // ---- streaming with 1-cycle memory, always ready ----
    use_model = 1'b1;
    do_reset();
    delivered = 0;
    exp_pc    = RPC;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      if (bus.if_valid) begin
        chk("stream_if_pc", bus.if_pc, exp_pc);
        chk("stream_if_instr", bus.if_instr, 32'hC000_0000 | exp_pc);
        exp_pc    = exp_pc + 32'd4;
        delivered = delivered + 1;
      end
    end
    chk("stream_delivered", 32'(delivered), 32'd26);

    // ---- decoder stalled: two buffered, requests stop, then resume ----
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("stall_c0_addr", bus.imem_req_addr, RPC);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("stall_c1_addr", bus.imem_req_addr, RPC + 32'd4);
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    end
    chk("stall_if_valid", 32'(bus.if_valid), 32'd1);
    chk("stall_if_pc", bus.if_pc, RPC);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("release_pc0", bus.if_pc, RPC);
    chk("release_req0", 32'(bus.imem_req_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("release_pc1", bus.if_pc, RPC + 32'd4);
    chk("release_req1", 32'(bus.imem_req_valid), 32'd1);
    chk("release_addr", bus.imem_req_addr, RPC + 32'd8);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("release_pc2", bus.if_pc, RPC + 32'd8);

    // ---- reset with a full buffer ----
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    end
    chk("full_before_rst", 32'(bus.if_valid), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RPC);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("post_rst_addr", bus.imem_req_addr, RPC);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("post_rst_if_valid0", 32'(bus.if_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("post_rst_if_pc", bus.if_pc, RPC);
    chk("post_rst_if_instr", bus.if_instr, 32'hC000_0000 | RPC);

    // ---- redirect with two requests outstanding (table-driven responses) ----
    use_model = 1'b0;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("rd2_out2_addr", bus.imem_req_addr, RPC + 32'd4);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'd0);
    chk("rd2_redir_req", 32'(bus.imem_req_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_0000);
    chk("rd2_drop0_req", 32'(bus.imem_req_valid), 32'd0);
    chk("rd2_drop0_ifv", 32'(bus.if_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_0004);
    chk("rd2_new_req", 32'(bus.imem_req_valid), 32'd1);
    chk("rd2_new_addr", bus.imem_req_addr, 32'h0000_0100);
    chk("rd2_drop1_ifv", 32'(bus.if_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_0100);
    chk("rd2_ifv_early", 32'(bus.if_valid), 32'd0);
    chk("rd2_addr2", bus.imem_req_addr, 32'h0000_0104);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hC000_0104);
    chk("rd2_if_pc0", bus.if_pc, 32'h0000_0100);
    chk("rd2_if_instr0", bus.if_instr, 32'hC000_0100);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("rd2_if_pc1", bus.if_pc, 32'h0000_0104);
    chk("rd2_if_instr1", bus.if_instr, 32'hC000_0104);

    // ---- redirect together with a response and a decoder pop ----
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_1000);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'hC000_1004);
    chk("rdc_if_pc", bus.if_pc, RPC);
    chk("rdc_req_valid", 32'(bus.imem_req_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("rdc_flush_ifv", 32'(bus.if_valid), 32'd0);
    chk("rdc_req_valid2", 32'(bus.imem_req_valid), 32'd1);
    chk("rdc_req_addr", bus.imem_req_addr, 32'h0000_0200);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_0200);
    chk("rdc_ifv_early", 32'(bus.if_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("rdc_if_pc2", bus.if_pc, 32'h0000_0200);
    chk("rdc_if_instr2", bus.if_instr, 32'hC000_0200);

    // ---- unaligned redirect target and pc wrap ----
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0);
    chk("wrap_redir_req", 32'(bus.imem_req_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("wrap_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_req0", 32'(bus.imem_req_valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("wrap_addr1", bus.imem_req_addr, 32'h0000_0000);
    chk("wrap_req1", 32'(bus.imem_req_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
